// File: rtl/rf_wb_scoreboard_if.sv
// ---------------------------------------------------------------------------
// rf_wb_scoreboard_if : issue, ALU writeback, load and RF write-port signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rf_wb_scoreboard_if;
  logic        issue_valid_i;
  logic [4:0]  issue_rs1_i;
  logic [4:0]  issue_rs2_i;
  logic        issue_use1_i;
  logic        issue_use2_i;
  logic [4:0]  issue_rd_i;
  logic        issue_rdwe_i;
  logic        issue_stall_o;
  logic        alu_wb_valid_i;
  logic [4:0]  alu_wb_rd_i;
  logic [31:0] alu_wb_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_dst_o;
  logic [31:0] rf_dst_d_o;
  logic        sb_err_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use1_i, issue_use2_i,
    output issue_rd_i, issue_rdwe_i, alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    input  issue_stall_o, ld_ready_o, rf_we_o, rf_dst_o, rf_dst_d_o, sb_err_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use1_i, issue_use2_i,
    input  issue_rd_i, issue_rdwe_i, alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    output issue_stall_o, ld_ready_o, rf_we_o, rf_dst_o, rf_dst_d_o, sb_err_o
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_wb_scoreboard : RAW/WAW issue interlock and ALU/load RF write-port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_wb_scoreboard #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rf_wb_scoreboard_if.slave   sb
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_t;

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  hold_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_cnt_nxt;
  logic [31:0]      r_busy, w_busy_nxt;
  logic [4:0]       r_hold_rd;
  logic [31:0]      r_hold_data;
  logic             r_err;
  logic             r_ld_wait;

  logic             w_ld_ready, w_ld_acc, w_starve, w_stall, w_set;
  logic             w_capture, w_req, w_we, w_rd0;
  logic [4:0]       w_req_rd;
  logic [31:0]      w_req_data;

  always_comb begin
    w_ld_ready = (r_state == S_EMPTY);
    w_ld_acc   = sb.ld_valid_i & w_ld_ready;
    w_starve   = (r_state == S_FULL) & (r_starve_cnt == C_LIMIT);
    // busy[0] is never set, so x0 operands cannot stall
    w_stall    = sb.issue_valid_i &
                 ((sb.issue_use1_i & r_busy[sb.issue_rs1_i]) |
                  (sb.issue_use2_i & r_busy[sb.issue_rs2_i]) |
                  (sb.issue_rdwe_i & r_busy[sb.issue_rd_i])  |
                  w_starve);
    w_set      = sb.issue_valid_i & ~w_stall & sb.issue_rdwe_i & (sb.issue_rd_i != 5'd0);

    w_req      = 1'b0;
    w_req_rd   = 5'd0;
    w_req_data = 32'd0;
    if (sb.alu_wb_valid_i) begin
      w_req      = 1'b1;
      w_req_rd   = sb.alu_wb_rd_i;
      w_req_data = sb.alu_wb_data_i;
    end else if (r_state == S_FULL) begin
      w_req      = 1'b1;
      w_req_rd   = r_hold_rd;
      w_req_data = r_hold_data;
    end else if (w_ld_acc) begin
      w_req      = 1'b1;
      w_req_rd   = sb.ld_rd_i;
      w_req_data = sb.ld_data_i;
    end
    w_we  = w_req & (w_req_rd != 5'd0);
    w_rd0 = w_req & (w_req_rd == 5'd0);

    w_state_nxt = r_state;
    w_cnt_nxt   = r_starve_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_ld_acc && sb.alu_wb_valid_i) begin
          w_state_nxt = S_FULL;
          w_capture   = 1'b1;
        end
      end
      S_FULL: begin
        if (!sb.alu_wb_valid_i) begin
          w_state_nxt = S_EMPTY;
          w_cnt_nxt   = '0;
        end else if (r_starve_cnt != C_LIMIT) begin
          w_cnt_nxt = r_starve_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase

    // set is applied after clear so a same-edge reissue keeps the register busy
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[w_req_rd] = 1'b0;
    if (w_set) w_busy_nxt[sb.issue_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_starve_cnt <= '0;
      r_busy       <= 32'd0;
      r_hold_rd    <= 5'd0;
      r_hold_data  <= 32'd0;
      r_err        <= 1'b0;
      r_ld_wait    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
      r_busy       <= w_busy_nxt;
      if (w_capture) begin
        r_hold_rd   <= sb.ld_rd_i;
        r_hold_data <= sb.ld_data_i;
      end
      r_ld_wait <= sb.ld_valid_i & ~w_ld_ready;
      r_err     <= r_err | (w_we & ~r_busy[w_req_rd]) | w_rd0 |
                   (r_ld_wait & ~sb.ld_valid_i);
    end
  end

  assign sb.issue_stall_o = w_stall;
  assign sb.ld_ready_o    = w_ld_ready;
  assign sb.rf_we_o       = w_we;
  assign sb.rf_dst_o      = w_we ? w_req_rd : 5'd0;
  assign sb.rf_dst_d_o    = w_we ? w_req_data : 32'd0;
  assign sb.sb_err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_scoreboard : directed stimulus with a write-port scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_scoreboard;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  rf_wb_scoreboard_if u_if ();

  rf_wb_scoreboard #(.STARVE_LIMIT(4), .CNT_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every RF write must match the oldest expected write
  always @(negedge clk) begin
    if (u_if.rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write x%0d=%0h expected none", u_if.rf_dst_o, u_if.rf_dst_d_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_dst", 32'(u_if.rf_dst_o), 32'(e.rd));
        chk("wb_data", u_if.rf_dst_d_o, e.d);
      end
    end
  end

  task automatic idle();
    u_if.issue_valid_i  = 1'b0;
    u_if.issue_rs1_i    = 5'd0;
    u_if.issue_rs2_i    = 5'd0;
    u_if.issue_use1_i   = 1'b0;
    u_if.issue_use2_i   = 1'b0;
    u_if.issue_rd_i     = 5'd0;
    u_if.issue_rdwe_i   = 1'b0;
    u_if.alu_wb_valid_i = 1'b0;
    u_if.alu_wb_rd_i    = 5'd0;
    u_if.alu_wb_data_i  = 32'd0;
    u_if.ld_valid_i     = 1'b0;
    u_if.ld_rd_i        = 5'd0;
    u_if.ld_data_i      = 32'd0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
    u_if.issue_valid_i = 1'b1;
    u_if.issue_rs1_i   = rs1;
    u_if.issue_use1_i  = u1;
    u_if.issue_rs2_i   = rs2;
    u_if.issue_use2_i  = u2;
    u_if.issue_rd_i    = rd;
    u_if.issue_rdwe_i  = we;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input logic expect_wr);
    u_if.alu_wb_valid_i = 1'b1;
    u_if.alu_wb_rd_i    = rd;
    u_if.alu_wb_data_i  = d;
    if (expect_wr) exp_q.push_back('{rd: rd, d: d});
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    u_if.ld_valid_i = 1'b1;
    u_if.ld_rd_i    = rd;
    u_if.ld_data_i  = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{rd: rd, d: d});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    chk("rst_stall", 32'(u_if.issue_stall_o), 32'd0);
    chk("rst_ready", 32'(u_if.ld_ready_o), 32'd1);
    chk("rst_we", 32'(u_if.rf_we_o), 32'd0);
    chk("rst_err", 32'(u_if.sb_err_o), 32'd0);
    nxt();
    rst_n = 1'b1;

    // RAW: reader of x5 waits for its ALU commit
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    @(negedge clk); chk("raw_issue_rd5", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("raw_stall", 32'(u_if.issue_stall_o), 32'd1);
    nxt(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); alu(5'd5, 32'hA5A5_0005, 1'b1);
    @(negedge clk); chk("raw_no_bypass", 32'(u_if.issue_stall_o), 32'd1);
    nxt(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("raw_release", 32'(u_if.issue_stall_o), 32'd0);

    // x0 never becomes busy
    nxt(); issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk); chk("x0_issue", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk); chk("x0_reissue", 32'(u_if.issue_stall_o), 32'd0);
    chk("x0_err", 32'(u_if.sb_err_o), 32'd0);

    // ALU and load collide: load is held one cycle
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    nxt(); alu(5'd3, 32'h3333_0003, 1'b1); ld(5'd7, 32'h7777_0007);
    @(negedge clk); chk("col_ready_empty", 32'(u_if.ld_ready_o), 32'd1);
    nxt(); expect_wr(5'd7, 32'h7777_0007);
    @(negedge clk); chk("col_ready_full", 32'(u_if.ld_ready_o), 32'd0);
    nxt();
    @(negedge clk); chk("col_ready_back", 32'(u_if.ld_ready_o), 32'd1);
    chk("col_err", 32'(u_if.sb_err_o), 32'd0);

    // Starvation: held load loses to the ALU until issue is frozen
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    for (int k = 10; k <= 14; k++) begin
      nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1);
    end
    nxt(); alu(5'd10, 32'h0A0A_000A, 1'b1); ld(5'd7, 32'hD7D7_0007);
    for (int k = 1; k <= 4; k++) begin
      nxt(); alu(5'(10 + k), 32'h0A0A_0000 + 32'(10 + k), 1'b1);
      issue(5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      chk("stv_no_stall", 32'(u_if.issue_stall_o), 32'd0);
      chk("stv_ready", 32'(u_if.ld_ready_o), 32'd0);
    end
    nxt(); issue(5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); expect_wr(5'd7, 32'hD7D7_0007);
    @(negedge clk); chk("stv_stall", 32'(u_if.issue_stall_o), 32'd1);
    nxt(); issue(5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("stv_unfreeze", 32'(u_if.issue_stall_o), 32'd0);
    chk("stv_ready_back", 32'(u_if.ld_ready_o), 32'd1);

    // WAW on x9
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    @(negedge clk); chk("waw_first", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    @(negedge clk); chk("waw_stall", 32'(u_if.issue_stall_o), 32'd1);
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); alu(5'd9, 32'h9999_0009, 1'b1);
    @(negedge clk); chk("waw_commit_stall", 32'(u_if.issue_stall_o), 32'd1);
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    @(negedge clk); chk("waw_reissue", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("waw_busy_again", 32'(u_if.issue_stall_o), 32'd1);
    chk("waw_err", 32'(u_if.sb_err_o), 32'd0);

    // Reset with the hold buffer full
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1);
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1);
    nxt(); alu(5'd15, 32'h1515_000F, 1'b1); ld(5'd16, 32'h1616_0010);
    nxt(); rst_n = 1'b0; issue(5'd16, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("rstf_ready", 32'(u_if.ld_ready_o), 32'd1);
    chk("rstf_we", 32'(u_if.rf_we_o), 32'd0);
    chk("rstf_busy", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); rst_n = 1'b1; alu(5'd16, 32'h1616_BEEF, 1'b1);
    @(negedge clk); chk("rstf_err_pre", 32'(u_if.sb_err_o), 32'd0);
    nxt();
    @(negedge clk); chk("rstf_err_set", 32'(u_if.sb_err_o), 32'd1);

    // Same-edge commit and issue of x20: set wins
    nxt(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1); alu(5'd20, 32'h2020_0014, 1'b1);
    @(negedge clk); chk("setwin_issue", 32'(u_if.issue_stall_o), 32'd0);
    nxt(); issue(5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("setwin_busy", 32'(u_if.issue_stall_o), 32'd1);

    // Write to x0 is dropped and flagged
    nxt(); rst_n = 1'b0;
    @(negedge clk); chk("x0w_err_clr", 32'(u_if.sb_err_o), 32'd0);
    nxt(); rst_n = 1'b1; alu(5'd0, 32'hDEAD_0000, 1'b0);
    @(negedge clk); chk("x0w_we", 32'(u_if.rf_we_o), 32'd0);
    nxt();
    @(negedge clk); chk("x0w_err", 32'(u_if.sb_err_o), 32'd1);

    nxt();
    @(negedge clk);
    chk("wb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
